aes_inv_cipher_core: RTL and testbench

Iterative AES-128 inverse cipher (decryption) datapath: takes one 128-bit ciphertext block and produces the plaintext block in 11 clock cycles, one round per cycle. It is the decrypt-side counterpart of the encryption round chain. It uses the same 128-bit state packing as the forward path and draws round keys from the existing key-schedule storage through an indexed fetch port. InvShiftRows, InvSubBytes, InvMixColumns and AddRoundKey are implemented internally.

---
 rtl/aes_inv_cipher_core.sv | 168 ++++++++++++++++
 tb/tb_aes_inv_cipher_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher: one round per clock, 11 cycles per block.
// Round keys come from an external key store addressed by rk_idx (combinational return on rk_in).
module aes_inv_cipher_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipher_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] plain_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] data_q, data_d;
    logic [127:0] plain_q, plain_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic [127:0] ark_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8];
        end
        return gf_inv(b ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) begin
            o[127 - 8 * b -: 8] = inv_sbox(s[127 - 8 * b -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign ark_s = inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_in;

    // Next-state, datapath update and key-index decode (from registered state only).
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        plain_d = plain_q;
        done_d  = 1'b0;
        rk_idx  = 4'd10;
        case (state_q)
            S_IDLE: begin
                rk_idx = 4'd10;
                if (start) begin
                    data_d  = cipher_in ^ rk_in;
                    round_d = 4'd9;
                    state_d = S_ROUND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUND: begin
                rk_idx  = round_q;
                data_d  = inv_mix_columns(ark_s);
                round_d = round_q - 4'd1;
                if (round_q == 4'd1) begin
                    state_d = S_FINAL;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_FINAL: begin
                rk_idx  = 4'd0;
                plain_d = ark_s;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            data_q  <= 128'h0;
            plain_q <= 128'h0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
            plain_q <= plain_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign plain_out = plain_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed bench for aes_inv_cipher_core using FIPS-197 App. B and C.1 vectors.
// The bench acts as the key store: rk_in is looked up from rk_idx in the same cycle.
module tb_aes_inv_cipher_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipher_in;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic         busy;
    logic         done;
    logic [127:0] plain_out;

    logic [127:0] ks [2][11];
    int           ks_sel;
    int           n_checks = 0;
    int           n_pass   = 0;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;

    aes_inv_cipher_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cipher_in (cipher_in),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .busy      (busy),
        .done      (done),
        .plain_out (plain_out)
    );

    always_comb begin
        rk_in = 128'h0;
        if (rk_idx <= 4'd10) begin
            rk_in = ks[ks_sel][rk_idx];
        end else begin
            rk_in = 128'h0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full block; inject pulses start at cycles 3 and 7 after accept (must be ignored).
    task automatic run_block(input int sel, input logic [127:0] ct, input logic [127:0] pt,
                             input bit inject);
        int cyc;
        int busy_cnt;
        bit trace_ok;
        @(negedge clk);
        ks_sel    = sel;
        cipher_in = ct;
        start     = 1'b1;
        check("accept_rk_idx", 128'(rk_idx), 128'(4'd10));
        check("accept_busy", 128'(busy), 128'(1'b0));
        @(negedge clk);
        start     = 1'b0;
        cipher_in = ~ct;
        cyc       = 1;
        busy_cnt  = 0;
        trace_ok  = 1'b1;
        while (!done && cyc < 30) begin
            if (cyc <= 10 && rk_idx !== 4'(10 - cyc)) trace_ok = 1'b0;
            if (busy) busy_cnt++;
            start = inject && (cyc == 3 || cyc == 7);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", 128'(cyc), 128'(11));
        check("rk_idx_trace", 128'(trace_ok), 128'(1'b1));
        check("busy_cycles", 128'(busy_cnt), 128'(10));
        check("done_pulse", 128'(done), 128'(1'b1));
        check("busy_low_at_done", 128'(busy), 128'(1'b0));
        check("plain_out", plain_out, pt);
        @(negedge clk);
        check("done_width", 128'(done), 128'(1'b0));
        check("plain_hold", plain_out, pt);
    endtask

    initial begin
        int cyc;
        int extra_done;
        bit stable_ok;

        ks[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
        ks[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        ks[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        ks[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        ks[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        ks[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        ks[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        ks[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        ks[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        ks[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        ks[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        ks[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ks[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ks[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ks[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ks[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ks[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ks[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ks[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ks[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ks[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
        ks[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        ks_sel    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        cipher_in = 128'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_plain", plain_out, 128'h0);
        check("rst_rk_idx", 128'(rk_idx), 128'(4'd10));
        rst = 1'b0;

        run_block(0, C1_CT, C1_PT, 1'b0);
        run_block(1, B_CT, B_PT, 1'b0);

        // Start pulses during a block must not queue a second block.
        run_block(0, C1_CT, C1_PT, 1'b1);
        extra_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("no_second_block", 128'(extra_done), 128'(0));

        // Back-to-back: start held high, C.1 then B.
        @(negedge clk);
        ks_sel    = 0;
        cipher_in = C1_CT;
        start     = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_lat1", 128'(cyc), 128'(11));
        check("b2b_plain1", plain_out, C1_PT);
        ks_sel    = 1;
        cipher_in = B_CT;
        @(negedge clk);
        cyc       = 1;
        stable_ok = 1'b1;
        while (!done && cyc < 30) begin
            if (plain_out !== C1_PT) stable_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("b2b_spacing", 128'(cyc), 128'(11));
        check("b2b_plain2", plain_out, B_PT);
        check("b2b_stable", 128'(stable_ok), 128'(1'b1));
        @(negedge clk);
        check("b2b_stop_busy", 128'(busy), 128'(1'b0));

        // Reset five cycles into a block aborts it.
        ks_sel    = 0;
        cipher_in = C1_CT;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'(1'b0));
        check("abort_done", 128'(done), 128'(1'b0));
        check("abort_plain", plain_out, 128'h0);
        check("abort_rk_idx", 128'(rk_idx), 128'(4'd10));
        rst = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("abort_no_done", 128'(extra_done), 128'(0));
        run_block(0, C1_CT, C1_PT, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
